ul4_ctrl: RTL
=============

Name: ul4_ctrl

Overview:
- Command-driven controller that issues operations to the 4-bit logic unit `ul4`, acting as its initiator.
- Holds a 4-entry x 4-bit register file. It accepts one command at a time over a valid/ready handshake: either load-immediate or logic-op.
- For a logic-op it drives the operands and select into `ul4` and writes the result back to the register file.
- Every command returns a response over a second valid/ready handshake.

Parameters:
- RESET_VAL, 4'b0000, value loaded into every register-file entry on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_load  input  1  1 = load immediate into rd; 0 = logic op.
- cmd_S  input  2  logic select: 00 ~A, 01 A^B, 10 A|B, 11 A&B.
- cmd_rd  input  2  destination register index.
- cmd_ra  input  2  source A register index.
- cmd_rb  input  2  source B register index (ignored for S=00 and for loads).
- cmd_imm  input  4  immediate value for loads.
- res_valid  output  1  response present.
- res_ready  input  1  consumer accepts response.
- res_data  output  4  value written to rd.
- res_rd  output  2  destination index of that value.
- res_zero  output  1  res_data == 4'b0000.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state=IDLE, all registers=RESET_VAL, res_data=0, res_rd=0, res_zero=0, res_valid=0.
- cmd_ready is combinational: 1 exactly when state==IDLE and reset==0.
- FSM states: IDLE, EXEC, RESP. Only one command is outstanding at a time.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge, latch cmd_load, cmd_S, cmd_rd, cmd_ra, cmd_rb, cmd_imm into internal command registers and go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - `ul4` inputs are A=regs[ra_q], B=regs[rb_q], S=S_q, driven combinationally from the latched fields.
  - At the edge: result = load_q ? imm_q : ul4 output.
  - Write regs[rd_q] <= result; res_data <= result; res_rd <= rd_q; res_zero <= (result==0).
  - Go to RESP. EXEC always lasts exactly one cycle.
- RESP:
  - res_valid=1.
  - When res_ready=1 at an edge, go to IDLE.
  - Otherwise hold res_data, res_rd and res_zero stable and stay in RESP.
- res_valid is driven from state (RESP) and is 0 in all other states.
- Latency: command accepted at edge t → register file updated and res_valid=1 from edge t+2. Response consumed at edge t+2+k → cmd_ready=1 in the following cycle.
- Throughput: at most one command per 3 cycles.
- Register indices:
  - ra, rb and rd may alias, e.g. rd=ra. The operands are read from register values before the EXEC-edge write.
  - A following command observes the written value.
- Input changes: changes on cmd_* while cmd_ready=0 are ignored. Commands are never queued.
- Reset mid-operation (any state): abort the in-flight command without a register-file write, return to IDLE, and re-initialise all registers to RESET_VAL.
- Reset and res_ready together: reset wins.
- Width: all datapath values are exactly 4 bits. No carries and no overflow.

Decomposition:
- Shared package `ul4_pkg` contains:
  - localparam select codes OP_NOT=2'b00, OP_XOR=2'b01, OP_OR=2'b10, OP_AND=2'b11.
  - FSM state encoding IDLE/EXEC/RESP.
  - REG_W=4, REG_N=4.
- One sub-module: the existing logic unit `ul4`, instantiated once and driven by the latched command fields.
- The register file and FSM stay inline in ul4_ctrl.

Test Plan:
- Reset then idle: assert reset for 2 cycles with cmd_valid=1 → cmd_ready=0 and res_valid=0 during reset, all registers read back 0, cmd_ready=1 in the first cycle after reset drops.
- Load then AND: load r0=4'b1100, then r1=4'b1010 (res_ready=1). Then op S=11, rd=2, ra=0, rb=1 → res_data=4'b1000, res_rd=2, res_zero=0, res_valid rises exactly 2 cycles after acceptance.
- All ops with the same operands r0=1100, r1=1010:
  - S=00 rd=3 → 0011.
  - S=01 → 0110.
  - S=10 → 1110.
  - S=11 with r0 AND r3(=0011) → 0000 and res_zero=1.
- Backpressure: hold res_ready=0 for 5 cycles in RESP → res_valid stays 1, res_data stable, cmd_ready=0. A cmd_valid pulse issued meanwhile is ignored, so that register file is unchanged.
- Aliasing: r0=0101, op S=00 rd=0 ra=0 → r0 becomes 1010. A next op S=01 rd=1 ra=0 rb=0 → 0000 with res_zero=1.
- Reset mid-EXEC: accept op targeting r2 (r2 previously 1111), assert reset in the EXEC cycle → no response, r2=RESET_VAL, FSM in IDLE.

Source files
------------

// File: rtl/ul4_pkg.sv
// Shared definitions for the ul4 logic unit and its command controller.
// Select codes, FSM encoding and register-file geometry.
package ul4_pkg;
    localparam int REG_W = 4;
    localparam int REG_N = 4;
    localparam int IDX_W = $clog2(REG_N);

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/ul4.sv
// 4-bit logic unit: ~A, A^B, A|B, A&B selected by s.
// Purely combinational, no handshake.
module ul4
    import ul4_pkg::*;
(
    input  logic [REG_W-1:0] a,
    input  logic [REG_W-1:0] b,
    input  logic [1:0]       s,
    output logic [REG_W-1:0] y
);
    always_comb begin
        y = '0;
        case (s)
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/ul4_ctrl.sv
// Command controller driving ul4 over a 4x4 register file; one command in flight.
// Latency: accept edge -> EXEC edge writes result -> res_valid; cmd_ready low until the response is taken.
module ul4_ctrl
    import ul4_pkg::*;
#(
    parameter logic [REG_W-1:0] RESET_VAL = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_S,
    input  logic [IDX_W-1:0] cmd_rd,
    input  logic [IDX_W-1:0] cmd_ra,
    input  logic [IDX_W-1:0] cmd_rb,
    input  logic [REG_W-1:0] cmd_imm,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [REG_W-1:0] res_data,
    output logic [IDX_W-1:0] res_rd,
    output logic             res_zero
);
    state_t           state_q, state_d;
    logic             load_q, load_d;
    logic [1:0]       s_q, s_d;
    logic [IDX_W-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic [REG_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0] regs_q [REG_N];
    logic [REG_W-1:0] regs_d [REG_N];
    logic [REG_W-1:0] res_data_q, res_data_d;
    logic [IDX_W-1:0] res_rd_q, res_rd_d;
    logic             res_zero_q, res_zero_d;
    logic [REG_W-1:0] alu_y;
    logic [REG_W-1:0] result;

    ul4 u_ul4 (
        .a (regs_q[ra_q]),
        .b (regs_q[rb_q]),
        .s (s_q),
        .y (alu_y)
    );

    assign result    = load_q ? imm_q : alu_y;
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign res_valid = (state_q == RESP);
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign res_zero  = res_zero_q;

    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        s_d        = s_q;
        rd_d       = rd_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        imm_d      = imm_q;
        regs_d     = regs_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        res_zero_d = res_zero_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    load_d  = cmd_load;
                    s_d     = cmd_S;
                    rd_d    = cmd_rd;
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    imm_d   = cmd_imm;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // operands come from regs_q, so rd aliasing ra/rb sees the pre-write value
                regs_d[rd_q] = result;
                res_data_d   = result;
                res_rd_d     = rd_q;
                res_zero_d   = (result == '0);
                state_d      = RESP;
            end
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            load_q     <= 1'b0;
            s_q        <= '0;
            rd_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            imm_q      <= '0;
            for (int i = 0; i < REG_N; i++) regs_q[i] <= RESET_VAL;
            res_data_q <= '0;
            res_rd_q   <= '0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            s_q        <= s_d;
            rd_q       <= rd_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            imm_q      <= imm_d;
            regs_q     <= regs_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
            res_zero_q <= res_zero_d;
        end
    end
endmodule
